uart_tx_fifo_arbiter: RTL and testbench

- Round-robin write-side arbiter that shares one UART TX FIFO among NUM_REQ producers, e.g. per-core UART ports in the multicore build.
- Each producer offers bytes over a valid/ready handshake. A granted producer keeps ownership until its message ends, so message bytes are not interleaved.
- Fairness is bounded by a maximum burst length and an idle timeout.
- Sits between the producer ports and the FIFO write port (write, write_data, full); the FIFO read side is untouched.

---
 rtl/uart_tx_fifo_arbiter_if.sv | 46 ++++
 rtl/uart_tx_fifo_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the UART TX FIFO arbiter.
//
//   req_valid       per-requester byte valid
//   req_last        per-requester end-of-message marker, sampled with valid
//   req_data        packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready       per-requester accept, one-hot or zero
//   fifo_full       FIFO full flag
//   fifo_write      FIFO write strobe
//   fifo_write_data FIFO write data
//
// modport slave  : the arbiter's view.
// modport master : the environment's view (producers plus FIFO).
interface uart_tx_fifo_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_write;
    logic [DATA_WIDTH-1:0]         fifo_write_data;

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_write,
        output fifo_write_data
    );

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_write,
        input  fifo_write_data
    );

endinterface

// File: rtl/uart_tx_fifo_arbiter.sv
// Round-robin write-side arbiter sharing one UART TX FIFO among NUM_REQ producers.
// A granted producer keeps the FIFO until its message ends (last), until MAX_BURST
// beats have been written, or until it has been silent for IDLE_TIMEOUT cycles.
// FIFO back-pressure stalls the owner but never revokes the grant.
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-high reset
//   bus       producer handshakes and FIFO write port (slave modport)
//   grant_id  current owner index, meaningful only while busy=1
//   busy      1 while a producer owns the FIFO
module uart_tx_fifo_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_fifo_arbiter_if.slave       bus,
    output logic [ID_WIDTH-1:0]         grant_id,
    output logic                        busy
);

    localparam logic [7:0]          MaxBurstW    = 8'(MAX_BURST);
    localparam logic [7:0]          IdleTimeoutW = 8'(IDLE_TIMEOUT);
    localparam logic [ID_WIDTH-1:0] LastReqId    = ID_WIDTH'(NUM_REQ - 1);
    // Zero-extended view of req_valid so any ID_WIDTH-bit index is in range.
    localparam int unsigned         NumSlots     = 2 ** ID_WIDTH;

    typedef enum logic [0:0] {
        StIdle,
        StOwn
    } state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [7:0]          idle_cnt_q, idle_cnt_d;

    logic [NumSlots-1:0]   valid_ext;
    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  beat;

    // Round-robin search starting just after last_grant, wrapping at NUM_REQ.
    always_comb begin
        valid_ext = NumSlots'(bus.req_valid);
        found     = 1'b0;
        winner    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned         sum;
            logic [ID_WIDTH-1:0] cand;
            sum = 32'(last_grant_q) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = ID_WIDTH'(sum);
            if (!found && valid_ext[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Select the current owner's handshake signals.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (ID_WIDTH'(j) == owner_q) begin
                owner_valid = bus.req_valid[j];
                owner_last  = bus.req_last[j];
                owner_data  = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gating beat with fifo_full keeps the write strobe off while the FIFO is full.
    assign beat = (state_q == StOwn) && owner_valid && !bus.fifo_full;

    always_comb begin
        bus.fifo_write      = beat;
        bus.fifo_write_data = (state_q == StOwn) ? owner_data : '0;
        bus.req_ready       = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            bus.req_ready[j] = beat && (ID_WIDTH'(j) == owner_q);
        end
        busy     = (state_q == StOwn);
        grant_id = owner_q;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        idle_cnt_d   = idle_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d      = StOwn;
                    owner_d      = winner;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                    idle_cnt_d   = '0;
                end
            end
            StOwn: begin
                if (beat) begin
                    if (owner_last || (beat_cnt_q + 8'd1 == MaxBurstW)) begin
                        // End of message or burst cap; last_grant already holds the
                        // owner, so it drops to lowest priority in the next search.
                        state_d    = StIdle;
                        beat_cnt_d = '0;
                        idle_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        idle_cnt_d = '0;
                    end
                end else if (!owner_valid) begin
                    if (idle_cnt_q + 8'd1 == IdleTimeoutW) begin
                        state_d    = StIdle;
                        beat_cnt_d = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
                // Owner valid but FIFO full: stall with counters frozen.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_grant_q <= LastReqId;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
module tb_uart_tx_fifo_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;

    int n_chk;
    int n_fail;

    uart_tx_fifo_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_fifo_arbiter #(
        .NUM_REQ      (4),
        .ID_WIDTH     (2),
        .DATA_WIDTH   (8),
        .MAX_BURST    (16),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a beat of requester id carrying byte b.
    task automatic chk_beat(input string tag, input int id, input int b);
        logic [3:0] one;
        one = 4'b0001;
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".gid"}, 32'(grant_id), 32'(id));
        chk({tag, ".wr"}, 32'(bus.fifo_write), 1);
        chk({tag, ".data"}, 32'(bus.fifo_write_data), 32'(b));
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(one << id));
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_chk            = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_last     = '0;
        bus.req_data     = '0;
        bus.fifo_full    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        chk("rst.busy", 32'(busy), 0);
        chk("rst.wr", 32'(bus.fifo_write), 0);
        chk("rst.ready", 32'(bus.req_ready), 0);
        chk("rst.gid", 32'(grant_id), 0);
        chk("rst.data", 32'(bus.fifo_write_data), 0);
        reset = 1'b0;

        // All four requesting 1-byte messages: grants rotate 0,1,2,3,0.
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr.idle_busy", 32'(busy), 0);
            chk("rr.idle_wr", 32'(bus.fifo_write), 0);
            step();
            chk_beat("rr", order[k], 8'h10 + order[k]);
            step();
        end
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Requester 2 sends A0..A4 while requester 1 waits.
        bus.req_valid = 4'b0100;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.req_valid        = 4'b0110;
            bus.req_last         = (i == 4) ? 4'b0110 : 4'b0010;
            bus.req_data[23:16]  = 8'(8'hA0 + i);
            bus.req_data[15:8]   = 8'h55;
            #1;
            chk_beat("msg2", 2, 8'hA0 + i);
            step();
        end
        bus.req_valid = 4'b0010;
        #1;
        chk("msg2.rel_busy", 32'(busy), 0);
        step();
        chk_beat("msg2.next1", 1, 8'h55);
        step();
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Burst cap: 16 bytes from 0, then 3, then 0 resumes with bytes 17..20.
        bus.req_valid = 4'b0001;
        bus.req_data  = '0;
        step();
        bus.req_valid        = 4'b1001;
        bus.req_last         = 4'b1000;
        bus.req_data[31:24]  = 8'h33;
        for (int b = 0; b < 16; b++) begin
            bus.req_data[7:0] = 8'(b);
            #1;
            chk_beat("burst0", 0, b);
            step();
        end
        chk("burst.cap_busy", 32'(busy), 0);
        step();
        chk_beat("burst.r3", 3, 8'h33);
        step();
        bus.req_valid = 4'b0001;
        #1;
        chk("burst.r3_rel", 32'(busy), 0);
        step();
        for (int b = 16; b < 20; b++) begin
            bus.req_data[7:0] = 8'(b);
            bus.req_last      = (b == 19) ? 4'b0001 : 4'b0000;
            #1;
            chk_beat("burst0b", 0, b);
            step();
        end
        chk("burst.end_busy", 32'(busy), 0);
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Idle timeout: owner 1 sends 2 bytes then goes silent for 8 cycles.
        bus.req_valid = 4'b0010;
        step();
        for (int i = 0; i < 2; i++) begin
            bus.req_data[15:8] = 8'(8'h60 + i);
            #1;
            chk_beat("idle1", 1, 8'h60 + i);
            step();
        end
        bus.req_valid = '0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk("idle.busy", 32'(busy), 1);
            chk("idle.wr", 32'(bus.fifo_write), 0);
            chk("idle.gid", 32'(grant_id), 1);
            step();
        end
        chk("idle.released", 32'(busy), 0);
        bus.req_valid      = 4'b0010;
        bus.req_last       = 4'b0010;
        bus.req_data[15:8] = 8'h62;
        step();
        chk_beat("idle.rearb", 1, 8'h62);
        step();
        bus.req_valid = '0;
        bus.req_last  = '0;
        #1;
        chk("idle.rearb_rel", 32'(busy), 0);

        // Back-pressure: 50 full cycles mid-message, grant kept, no timeout.
        bus.req_valid       = 4'b0100;
        bus.req_data[23:16] = 8'hB0;
        step();
        chk_beat("full.b0", 2, 8'hB0);
        step();
        bus.fifo_full       = 1'b1;
        bus.req_data[23:16] = 8'hB1;
        bus.req_last        = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            #1;
            chk("full.wr", 32'(bus.fifo_write), 0);
            chk("full.ready", 32'(bus.req_ready), 0);
            chk("full.busy", 32'(busy), 1);
            chk("full.gid", 32'(grant_id), 2);
            step();
        end
        bus.fifo_full = 1'b0;
        #1;
        chk_beat("full.resume", 2, 8'hB1);
        step();
        bus.req_valid = '0;
        bus.req_last  = '0;
        #1;
        chk("full.rel", 32'(busy), 0);

        // Reset in the middle of a message, then requester 0 wins first.
        bus.req_valid       = 4'b0100;
        bus.req_data[23:16] = 8'hC0;
        step();
        for (int i = 0; i < 2; i++) begin
            bus.req_data[23:16] = 8'(8'hC0 + i);
            #1;
            chk_beat("mrst", 2, 8'hC0 + i);
            step();
        end
        bus.req_data[23:16] = 8'hC2;
        #1;
        chk_beat("mrst.b3", 2, 8'hC2);
        reset = 1'b1;
        #1;
        chk("mrst.busy", 32'(busy), 0);
        chk("mrst.wr", 32'(bus.fifo_write), 0);
        chk("mrst.ready", 32'(bus.req_ready), 0);
        chk("mrst.gid", 32'(grant_id), 0);
        reset         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        chk("mrst.idle_busy", 32'(busy), 0);
        step();
        chk_beat("mrst.first0", 0, 8'h10);
        step();
        bus.req_valid = '0;
        bus.req_last  = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
